// File: rtl/seg7_scan_if.sv
// Bundles the frame-load handshake and the display-side outputs of the
// 7-segment scan controller.
interface seg7_scan_if #(
    parameter int NUM_DIGITS = 4,
    parameter int CODE_W     = 3
);
    logic                           enable;
    logic                           load;
    logic [NUM_DIGITS*CODE_W-1:0]   data_in;
    logic                           load_ack;
    logic [CODE_W-1:0]              code_out;
    logic [NUM_DIGITS-1:0]          digit_sel;
    logic                           blank;
    logic                           frame_done;

    modport master (
        output enable, load, data_in,
        input  load_ack, code_out, digit_sel, blank, frame_done
    );

    modport slave (
        input  enable, load, data_in,
        output load_ack, code_out, digit_sel, blank, frame_done
    );
endinterface

// File: rtl/seg7_scan_ctrl.sv
// Scans NUM_DIGITS 3-bit codes onto one shared 7-segment decoder with a
// blanking guard before each digit; new frames are applied only at frame ends.
module seg7_scan_ctrl #(
    parameter int NUM_DIGITS   = 4,
    parameter int CODE_W       = 3,
    parameter int REFRESH_DIV  = 1000,
    parameter int BLANK_CYCLES = 2
) (
    input logic        clk,
    input logic        rst,
    seg7_scan_if.slave bus
);
    localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int CNT_MAX = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int FRAME_W = NUM_DIGITS * CODE_W;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

    typedef enum logic [1:0] {IDLE, BLANK, SHOW} state_t;

    state_t               state;
    logic [IDX_W-1:0]     idx;
    logic [CNT_W-1:0]     div_cnt;
    logic [FRAME_W-1:0]   active;
    logic [FRAME_W-1:0]   shadow;
    logic                 pending;

    logic [CODE_W-1:0]    code_out;
    logic [NUM_DIGITS-1:0] digit_sel;
    logic                 blank;
    logic                 frame_done;
    logic                 load_ack;

    logic                 enable;
    logic                 load;
    logic [FRAME_W-1:0]   data_in;

    logic                 at_boundary;
    logic [FRAME_W-1:0]   active_nxt;
    logic [FRAME_W-1:0]   shadow_nxt;
    logic                 pending_nxt;

    assign enable  = bus.enable;
    assign load    = bus.load;
    assign data_in = bus.data_in;

    assign bus.code_out   = code_out;
    assign bus.digit_sel  = digit_sel;
    assign bus.blank      = blank;
    assign bus.frame_done = frame_done;
    assign bus.load_ack   = load_ack;

    function automatic logic [CODE_W-1:0] code_at(input logic [FRAME_W-1:0] vec,
                                                  input logic [IDX_W-1:0]   k);
        return vec[int'(k)*CODE_W +: CODE_W];
    endfunction

    function automatic logic [NUM_DIGITS-1:0] onehot(input logic [IDX_W-1:0] k);
        return NUM_DIGITS'(1) << k;
    endfunction

    // Frame buffer: the displayed frame only changes while disabled or on the
    // edge that closes the last digit, so a visible frame is never mixed.
    always_comb begin
        at_boundary = enable && (state == SHOW) &&
                      (div_cnt == CNT_W'(REFRESH_DIV - 1)) && (idx == LAST_IDX);
        active_nxt  = active;
        shadow_nxt  = shadow;
        pending_nxt = pending;
        if (load) begin
            if (state == IDLE || at_boundary) begin
                active_nxt  = data_in;
                pending_nxt = 1'b0;
            end else begin
                shadow_nxt  = data_in;
                pending_nxt = 1'b1;
            end
        end else if (at_boundary && pending) begin
            active_nxt  = shadow;
            pending_nxt = 1'b0;
        end
    end

    // Outputs are computed from the next state so they are registered in
    // step with it; frame_done is raised one cycle early so it covers the
    // final SHOW cycle, i.e. the cycle whose closing edge is the boundary.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            idx        <= '0;
            div_cnt    <= '0;
            active     <= '0;
            shadow     <= '0;
            pending    <= 1'b0;
            code_out   <= '0;
            digit_sel  <= '0;
            blank      <= 1'b1;
            frame_done <= 1'b0;
            load_ack   <= 1'b0;
        end else begin
            active     <= active_nxt;
            shadow     <= shadow_nxt;
            pending    <= pending_nxt;
            load_ack   <= load;
            frame_done <= 1'b0;
            if (!enable) begin
                state     <= IDLE;
                idx       <= '0;
                div_cnt   <= '0;
                digit_sel <= '0;
                blank     <= 1'b1;
            end else begin
                case (state)
                    IDLE: begin
                        state     <= BLANK;
                        idx       <= '0;
                        div_cnt   <= '0;
                        digit_sel <= '0;
                        blank     <= 1'b1;
                        code_out  <= code_at(active_nxt, '0);
                    end
                    BLANK: begin
                        if (div_cnt == CNT_W'(BLANK_CYCLES - 1)) begin
                            state     <= SHOW;
                            div_cnt   <= '0;
                            digit_sel <= onehot(idx);
                            blank     <= 1'b0;
                            code_out  <= code_at(active_nxt, idx);
                            if (idx == LAST_IDX && REFRESH_DIV == 1)
                                frame_done <= 1'b1;
                        end else begin
                            div_cnt <= div_cnt + CNT_W'(1);
                        end
                    end
                    SHOW: begin
                        if (div_cnt == CNT_W'(REFRESH_DIV - 1)) begin
                            state     <= BLANK;
                            div_cnt   <= '0;
                            digit_sel <= '0;
                            blank     <= 1'b1;
                            if (idx == LAST_IDX) begin
                                idx      <= '0;
                                code_out <= code_at(active_nxt, '0);
                            end else begin
                                idx      <= idx + IDX_W'(1);
                                code_out <= code_at(active_nxt, idx + IDX_W'(1));
                            end
                        end else begin
                            div_cnt <= div_cnt + CNT_W'(1);
                            if (idx == LAST_IDX && int'(div_cnt) + 2 == REFRESH_DIV)
                                frame_done <= 1'b1;
                        end
                    end
                    default: begin
                        state     <= IDLE;
                        digit_sel <= '0;
                        blank     <= 1'b1;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed bench for seg7_scan_ctrl: 4 digits, 4-cycle refresh, 2 blank
// cycles (24-cycle frame); expectations are hand-derived frame timelines.
module tb_seg7_scan_ctrl;
    localparam int NUM_DIGITS   = 4;
    localparam int CODE_W       = 3;
    localparam int REFRESH_DIV  = 4;
    localparam int BLANK_CYCLES = 2;

    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_err = 0;
    logic ack_due = 1'b0;
    int   frame_no = 0;

    seg7_scan_if #(.NUM_DIGITS(NUM_DIGITS), .CODE_W(CODE_W)) bus ();

    seg7_scan_ctrl #(
        .NUM_DIGITS  (NUM_DIGITS),
        .CODE_W      (CODE_W),
        .REFRESH_DIV (REFRESH_DIV),
        .BLANK_CYCLES(BLANK_CYCLES)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_ctrl(input string tag, input logic [3:0] sel, input logic blk,
                            input logic fd, input logic ack);
        chk({tag, " sel"},   32'(bus.digit_sel),  32'(sel));
        chk({tag, " blank"}, 32'(bus.blank),      32'(blk));
        chk({tag, " fdone"}, 32'(bus.frame_done), 32'(fd));
        chk({tag, " ack"},   32'(bus.load_ack),   32'(ack));
    endtask

    // Walks n_off cycles of a frame starting at offset 0 (first blank cycle of
    // digit 0), optionally pulsing load at offsets la and lb.
    task automatic run_frame(input logic [11:0] codes, input int n_off,
                             input int la, input logic [11:0] da,
                             input int lb, input logic [11:0] db);
        int    k;
        int    j;
        string tag;
        frame_no++;
        for (int p = 0; p < n_off; p++) begin
            k   = p / 6;
            j   = p % 6;
            tag = $sformatf("f%0d p%0d", frame_no, p);
            chk_ctrl(tag, (j < 2) ? 4'b0000 : 4'(1 << k), j < 2, p == 23, ack_due);
            chk({tag, " code"}, 32'(bus.code_out), 32'(codes[k*3 +: 3]));
            ack_due = 1'b0;
            if (p == la) begin
                bus.load = 1'b1; bus.data_in = da; ack_due = 1'b1;
            end else if (p == lb) begin
                bus.load = 1'b1; bus.data_in = db; ack_due = 1'b1;
            end
            tick();
            bus.load = 1'b0;
        end
    endtask

    initial begin
        rst = 1'b1;
        bus.enable  = 1'b1;
        bus.load    = 1'b0;
        bus.data_in = 12'o7777;
        #1;
        // 1. reset hold with activity on the inputs
        for (int i = 0; i < 4; i++) begin
            bus.load = ~bus.load;
            tick();
            chk_ctrl($sformatf("rsthold%0d", i), 4'b0000, 1'b1, 1'b0, 1'b0);
            chk($sformatf("rsthold%0d code", i), 32'(bus.code_out), 32'd0);
        end
        rst = 1'b0; bus.enable = 1'b0; bus.load = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            chk_ctrl($sformatf("postrst%0d", i), 4'b0000, 1'b1, 1'b0, 1'b0);
            chk($sformatf("postrst%0d code", i), 32'(bus.code_out), 32'd0);
        end

        // 2. load in IDLE, then scan
        bus.load = 1'b1; bus.data_in = 12'o7531;
        tick();
        bus.load = 1'b0;
        chk_ctrl("idleload", 4'b0000, 1'b1, 1'b0, 1'b1);
        tick();
        chk_ctrl("idleload+1", 4'b0000, 1'b1, 1'b0, 1'b0);
        bus.enable = 1'b1;
        tick();
        run_frame(12'o7531, 24, -1, 12'o0, -1, 12'o0);

        // 3. tear-free update while digit 1 is showing
        run_frame(12'o7531, 24, 8, 12'o0246, -1, 12'o0);
        run_frame(12'o0246, 24, -1, 12'o0, -1, 12'o0);

        // 4. last load wins, then a load on the frame_done cycle
        run_frame(12'o0246, 24, 3, 12'o1111, 14, 12'o2222);
        run_frame(12'o2222, 24, 23, 12'o3333, -1, 12'o0);
        run_frame(12'o3333, 24, -1, 12'o0, -1, 12'o0);

        // 5. disable while digit 2 shows; a load in that cycle stays pending
        run_frame(12'o3333, 14, -1, 12'o0, -1, 12'o0);
        chk_ctrl("dis pre", 4'b0100, 1'b0, 1'b0, 1'b0);
        bus.enable = 1'b0;
        bus.load = 1'b1; bus.data_in = 12'o5555;
        tick();
        bus.load = 1'b0;
        chk_ctrl("dis edge", 4'b0000, 1'b1, 1'b0, 1'b1);
        ack_due = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_ctrl($sformatf("dis idle%0d", i), 4'b0000, 1'b1, 1'b0, 1'b0);
        end
        bus.enable = 1'b1;
        tick();
        run_frame(12'o3333, 24, -1, 12'o0, -1, 12'o0);
        run_frame(12'o5555, 10, 3, 12'o6666, -1, 12'o0);

        // 6. asynchronous reset mid-SHOW with a load pending
        chk_ctrl("pre-arst", 4'b0010, 1'b0, 1'b0, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        chk_ctrl("arst", 4'b0000, 1'b1, 1'b0, 1'b0);
        chk("arst code", 32'(bus.code_out), 32'd0);
        bus.enable = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        chk_ctrl("arst rel", 4'b0000, 1'b1, 1'b0, 1'b0);
        bus.enable = 1'b1;
        tick();
        run_frame(12'o0000, 24, -1, 12'o0, -1, 12'o0);
        run_frame(12'o0000, 24, -1, 12'o0, -1, 12'o0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
